// File: rtl/bcd_add_controller.sv
// bcd_add_controller
//   Step-by-step sequencer for the BCD adder lab datapath. Each press of the
//   debounced step button launches one request toward the datapath, and the
//   controller waits for the matching acknowledge. The full walk is:
//   load A, show A, load B, show B, show low result, show high result.
//   A watchdog moves the controller to ERROR if an acknowledge never arrives.
//
// Parameters
//   ACK_TIMEOUT  cycles a request may stay unacknowledged (1..65535)
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   step              one-cycle step pulse
//   *_ack             level acknowledges from the datapath
//   load_a .. display_ms  registered one-hot requests to the datapath
//   phase             encoded state, for LEDs
//   busy              high in any request state
//   error             high in ERROR
module bcd_add_controller #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       step,
  input  logic       load_a_ack,
  input  logic       load_b_ack,
  input  logic       display_a_ack,
  input  logic       display_b_ack,
  input  logic       display_ls_ack,
  input  logic       display_ms_ack,
  output logic       load_a,
  output logic       load_b,
  output logic       display_a,
  output logic       display_b,
  output logic       display_ls,
  output logic       display_ms,
  output logic [3:0] phase,
  output logic       busy,
  output logic       error
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(ACK_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    REQ_LA  = 4'd1,
    REQ_DA  = 4'd2,
    HOLD_A  = 4'd3,
    REQ_LB  = 4'd4,
    REQ_DB  = 4'd5,
    HOLD_B  = 4'd6,
    REQ_LS  = 4'd7,
    HOLD_LS = 4'd8,
    REQ_MS  = 4'd9,
    HOLD_MS = 4'd10,
    ERR     = 4'd15
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_to;
  logic          w_in_req;

  // Watchdog fires once the count has reached the limit; the ack is tested
  // ahead of it in the next-state logic so a coincident ack still advances.
  assign w_to = (r_cnt == TO_CNT);

  always_comb begin
    w_in_req = 1'b0;
    case (r_state)
      REQ_LA, REQ_DA, REQ_LB, REQ_DB, REQ_LS, REQ_MS: w_in_req = 1'b1;
      default:                                        w_in_req = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (step) w_nxt = REQ_LA;
      REQ_LA:  if (load_a_ack)     w_nxt = REQ_DA;
               else if (w_to)     w_nxt = ERR;
      REQ_DA:  if (display_a_ack)  w_nxt = HOLD_A;
               else if (w_to)     w_nxt = ERR;
      HOLD_A:  if (step) w_nxt = REQ_LB;
      REQ_LB:  if (load_b_ack)     w_nxt = REQ_DB;
               else if (w_to)     w_nxt = ERR;
      REQ_DB:  if (display_b_ack)  w_nxt = HOLD_B;
               else if (w_to)     w_nxt = ERR;
      HOLD_B:  if (step) w_nxt = REQ_LS;
      REQ_LS:  if (display_ls_ack) w_nxt = HOLD_LS;
               else if (w_to)     w_nxt = ERR;
      HOLD_LS: if (step) w_nxt = REQ_MS;
      REQ_MS:  if (display_ms_ack) w_nxt = HOLD_MS;
               else if (w_to)     w_nxt = ERR;
      HOLD_MS: if (step) w_nxt = IDLE;
      ERR:     if (step) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so a request rises on the same
  // edge that samples the step (or previous ack) and falls on the ack edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      load_a     <= 1'b0;
      load_b     <= 1'b0;
      display_a  <= 1'b0;
      display_b  <= 1'b0;
      display_ls <= 1'b0;
      display_ms <= 1'b0;
      phase      <= 4'd0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      // Any state change clears the count, which covers entry to every
      // request state. Staying in a request state implies the ack was low,
      // and the count cannot pass the limit because that edge leaves.
      if (w_nxt != r_state) r_cnt <= '0;
      else if (w_in_req)    r_cnt <= r_cnt + 1'b1;
      load_a     <= (w_nxt == REQ_LA);
      display_a  <= (w_nxt == REQ_DA);
      load_b     <= (w_nxt == REQ_LB);
      display_b  <= (w_nxt == REQ_DB);
      display_ls <= (w_nxt == REQ_LS);
      display_ms <= (w_nxt == REQ_MS);
      busy       <= (w_nxt == REQ_LA) || (w_nxt == REQ_DA) ||
                    (w_nxt == REQ_LB) || (w_nxt == REQ_DB) ||
                    (w_nxt == REQ_LS) || (w_nxt == REQ_MS);
      error      <= (w_nxt == ERR);
      phase      <= w_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_add_controller.sv
// Directed bench for bcd_add_controller: a configurable-latency ack model,
// a phase scoreboard fed by the stimulus, and per-cycle output decoding.
module tb_bcd_add_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       step = 1'b0;
  logic [5:0] req, ack, mdl, force_a, kill;
  logic [3:0] phase;
  logic       busy, error;
  logic [5:0] req4, ack4;
  logic [3:0] phase4;
  logic       busy4, error4;

  int checks = 0;
  int errors = 0;
  int dly = 1;
  int cnt[6];
  int run[6];
  int lastw[6];
  logic [3:0] sb[$];
  logic [3:0] last_ph;

  always #5 CLK = ~CLK;

  // bit order: 0 load_a, 1 display_a, 2 load_b, 3 display_b, 4 ls, 5 ms
  bcd_add_controller #(.ACK_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .step(step),
    .load_a_ack(ack[0]), .display_a_ack(ack[1]), .load_b_ack(ack[2]),
    .display_b_ack(ack[3]), .display_ls_ack(ack[4]), .display_ms_ack(ack[5]),
    .load_a(req[0]), .display_a(req[1]), .load_b(req[2]),
    .display_b(req[3]), .display_ls(req[4]), .display_ms(req[5]),
    .phase(phase), .busy(busy), .error(error));

  bcd_add_controller #(.ACK_TIMEOUT(4)) dut4 (
    .CLK(CLK), .RST(RST), .step(step),
    .load_a_ack(ack4[0]), .display_a_ack(ack4[1]), .load_b_ack(ack4[2]),
    .display_b_ack(ack4[3]), .display_ls_ack(ack4[4]), .display_ms_ack(ack4[5]),
    .load_a(req4[0]), .display_a(req4[1]), .load_b(req4[2]),
    .display_b(req4[3]), .display_ls(req4[4]), .display_ms(req4[5]),
    .phase(phase4), .busy(busy4), .error(error4));

  // Datapath model: ack rises after the request has been seen for dly edges.
  always @(posedge CLK) begin
    for (int i = 0; i < 6; i++) begin
      if (req[i]) begin
        cnt[i] <= cnt[i] + 1;
        mdl[i] <= ((cnt[i] + 1) >= dly);
      end else begin
        cnt[i] <= 0;
        mdl[i] <= 1'b0;
      end
    end
  end
  assign ack = (mdl & ~kill) | force_a;

  function automatic logic [5:0] exp_req(input logic [3:0] p);
    case (p)
      4'd1:    return 6'b000001;
      4'd2:    return 6'b000010;
      4'd4:    return 6'b000100;
      4'd5:    return 6'b001000;
      4'd7:    return 6'b010000;
      4'd9:    return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Request high-time measurement, sampled away from the active edge.
  always @(negedge CLK) begin
    for (int i = 0; i < 6; i++) begin
      if (req[i]) run[i] <= run[i] + 1;
      else if (run[i] != 0) begin
        lastw[i] <= run[i];
        run[i]   <= 0;
      end
    end
  end

  // Scoreboard pop on every phase change plus per-cycle output decoding.
  always @(negedge CLK) begin
    if (RST) last_ph <= phase;
    else begin
      chk("req_decode", {26'd0, req}, {26'd0, exp_req(phase)});
      chk("busy", {31'd0, busy}, {31'd0, (exp_req(phase) != 6'd0)});
      chk("error", {31'd0, error}, {31'd0, (phase == 4'd15)});
      if (phase != last_ph) begin
        chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) chk("sb_phase", {28'd0, phase}, {28'd0, sb.pop_front()});
      end
      last_ph <= phase;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_ph(input string tag, input logic [3:0] p, input int budget);
    int n = 0;
    while (phase !== p && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {28'd0, phase}, {28'd0, p});
  endtask

  task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(c);
  endtask

  initial begin
    force_a = '0;
    kill    = '0;
    ack4    = '0;
    for (int i = 0; i < 6; i++) begin
      cnt[i] = 0; run[i] = 0; lastw[i] = 0;
    end

    // reset state
    repeat (3) tick();
    chk("rst_phase", {28'd0, phase}, 32'd0);
    chk("rst_req", {26'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_phase4", {28'd0, phase4}, 32'd0);
    chk("rst_req4", {26'd0, req4}, 32'd0);
    RST = 1'b0;
    repeat (2) tick();

    // full sequence with 1-cycle ack datapath
    push3(4'd1, 4'd2, 4'd3);
    pulse();
    wait_ph("seq_hold_a", 4'd3, 20); repeat (8) tick();
    chk("seq_w_load_a", lastw[0], 32'd2);
    chk("seq_w_disp_a", lastw[1], 32'd2);
    push3(4'd4, 4'd5, 4'd6);
    pulse();
    wait_ph("seq_hold_b", 4'd6, 20); repeat (8) tick();
    chk("seq_w_load_b", lastw[2], 32'd2);
    chk("seq_w_disp_b", lastw[3], 32'd2);
    sb.push_back(4'd7); sb.push_back(4'd8);
    pulse();
    wait_ph("seq_hold_ls", 4'd8, 20); repeat (8) tick();
    chk("seq_w_ls", lastw[4], 32'd2);
    sb.push_back(4'd9); sb.push_back(4'd10);
    pulse();
    wait_ph("seq_hold_ms", 4'd10, 20); repeat (8) tick();
    chk("seq_w_ms", lastw[5], 32'd2);
    sb.push_back(4'd0);
    pulse();
    wait_ph("seq_idle", 4'd0, 20); repeat (8) tick();

    // sticky display_a_ack completes REQ_DA on its first edge
    force_a[1] = 1'b1;
    push3(4'd1, 4'd2, 4'd3);
    pulse();
    wait_ph("sticky_hold_a", 4'd3, 20); tick();
    chk("sticky_w_disp_a", lastw[1], 32'd1);
    chk("sticky_w_load_a", lastw[0], 32'd2);
    force_a[1] = 1'b0;
    repeat (3) tick();

    // step every cycle while acks take 5 cycles: no skipped states
    dly = 5;
    push3(4'd4, 4'd5, 4'd6);
    push3(4'd7, 4'd8, 4'd9);
    sb.push_back(4'd10);
    begin
      int n = 0;
      step = 1'b1;
      while (phase !== 4'd10 && n < 200) begin
        tick();
        n++;
      end
      step = 1'b0;
    end
    chk("ign_hold_ms", {28'd0, phase}, 32'd10);
    tick();
    chk("ign_w_ms", lastw[5], 32'd6);
    chk("ign_w_load_b", lastw[2], 32'd6);
    dly = 1;
    sb.push_back(4'd0);
    pulse();
    wait_ph("ign_idle", 4'd0, 10); repeat (3) tick();

    // watchdog: load_b never acknowledged, ACK_TIMEOUT=8
    push3(4'd1, 4'd2, 4'd3);
    pulse();
    wait_ph("to_hold_a", 4'd3, 20); repeat (3) tick();
    kill[2] = 1'b1;
    sb.push_back(4'd4); sb.push_back(4'd15);
    pulse();
    wait_ph("to_error_phase", 4'd15, 30); tick();
    chk("to_w_load_b", lastw[2], 32'd9);
    chk("to_error_flag", {31'd0, error}, 32'd1);
    sb.push_back(4'd0);
    pulse();
    chk("to_clr_phase", {28'd0, phase}, 32'd0);
    chk("to_clr_error", {31'd0, error}, 32'd0);
    kill[2] = 1'b0;
    repeat (3) tick();

    // reset while display_ls is outstanding
    push3(4'd1, 4'd2, 4'd3);
    pulse();
    wait_ph("rm_hold_a", 4'd3, 20); repeat (3) tick();
    push3(4'd4, 4'd5, 4'd6);
    pulse();
    wait_ph("rm_hold_b", 4'd6, 20); repeat (3) tick();
    kill[4] = 1'b1;
    sb.push_back(4'd7);
    pulse();
    repeat (3) tick();
    chk("rm_ls_high", {31'd0, req[4]}, 32'd1);
    sb.push_back(4'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rm_phase", {28'd0, phase}, 32'd0);
    chk("rm_req", {26'd0, req}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_error", {31'd0, error}, 32'd0);
    force_a[4] = 1'b1;
    repeat (4) tick();
    chk("rm_late_ack", {28'd0, phase}, 32'd0);
    force_a[4] = 1'b0;
    kill[4] = 1'b0;
    tick();

    // ack/timeout race on the ACK_TIMEOUT=4 instance
    push3(4'd1, 4'd2, 4'd3);
    pulse();
    chk("race_req_la", {28'd0, phase4}, 32'd1);
    repeat (4) tick();
    chk("race_pre", {28'd0, phase4}, 32'd1);
    ack4[0] = 1'b1;
    tick();
    ack4[0] = 1'b0;
    chk("race_adv", {28'd0, phase4}, 32'd2);
    chk("race_no_err", {31'd0, error4}, 32'd0);
    wait_ph("race_main_hold_a", 4'd3, 20);
    repeat (2) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_add_controller.md
# bcd_add_controller

Sequencing controller for the BCD adder lab datapath. It walks the user through the full operation, one step per button press: load A, show A, load B, show B, show the low result, show the high result. For each step it raises one request line into the datapath and waits for the matching acknowledge. A watchdog moves it to an error state if an acknowledge never arrives. It sits between the debounced front-panel step button and the adder datapath; `input_value` and `output_value` bypass this block.

## Interface
- `ACK_TIMEOUT`, default 255: cycles a request may stay unacknowledged before the controller enters ERROR. Legal range 1..65535.
- `CLK` input 1: single system clock; all logic on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `step` input 1: one-cycle pulse from the debounced step button.
- `load_a_ack`, `load_b_ack`, `display_a_ack`, `display_b_ack`, `display_ls_ack`, `display_ms_ack` input 1 each: level acknowledges from the datapath.
- `load_a`, `load_b`, `display_a`, `display_b`, `display_ls`, `display_ms` output 1 each: registered requests to the datapath.
- `phase` output 4: encoded current state, for LEDs.
- `busy` output 1: high while any request is outstanding.
- `error` output 1: high while in ERROR.

## Operation
- States and `phase` codes:
  - IDLE=0
  - REQ_LA=1, REQ_DA=2, HOLD_A=3
  - REQ_LB=4, REQ_DB=5, HOLD_B=6
  - REQ_LS=7, HOLD_LS=8
  - REQ_MS=9, HOLD_MS=10
  - ERROR=15
- Transitions:
  - IDLE -step-> REQ_LA -load_a_ack-> REQ_DA -display_a_ack-> HOLD_A.
  - HOLD_A -step-> REQ_LB -load_b_ack-> REQ_DB -display_b_ack-> HOLD_B.
  - HOLD_B -step-> REQ_LS -display_ls_ack-> HOLD_LS.
  - HOLD_LS -step-> REQ_MS -display_ms_ack-> HOLD_MS -step-> IDLE.
- Request decoding (Moore, registered): exactly one request is high in each REQ_* state (REQ_LA→`load_a`, REQ_DA→`display_a`, and so on). All requests are low in IDLE, HOLD_* and ERROR.
- Acknowledge handling:
  - Only the ack matching the current request is examined; all other acks are ignored.
  - Acks are not required to return low. An ack already high on state entry completes that step at the first edge.
- `step` handling: `step` is ignored in every REQ_* state and is never queued.
- Watchdog:
  - A counter, width clog2(ACK_TIMEOUT+1), clears on entry to every REQ_* state and increments each cycle the ack is low.
  - When the count reaches ACK_TIMEOUT, the next state is ERROR.
  - If the ack and the timeout land on the same edge, the ack wins.
- ERROR: all requests drop and `error` goes high. `step` returns the controller to IDLE and clears `error`.
- `busy` is high exactly when in a REQ_* state.

## Timing
- Reset values: state IDLE; all requests, `busy` and `error` 0; `phase` 0; counter 0.
- `RST` sampled high sets all outputs to reset values at that edge.
- Reset mid-request drops the request at the same edge; no ack is awaited afterwards.
- Reset beats `step` when both arrive on the same edge.
- Step to request: `step` sampled high at edge k in IDLE/HOLD_* → the request is high from edge k.
- Request to next state: the matching ack sampled high at edge m → the request drops at edge m and the next state is entered at edge m.
- Against a datapath that registers its ack one edge after seeing the request, each request lasts exactly 2 cycles.
- Minimum full sequence: 4 step presses plus 6 ack handshakes.
- Timeout: with the ack held low, ERROR is entered ACK_TIMEOUT+1 edges after the request rose.

## Test plan
- Full sequence:
  - Stimulus: reset; a 1-cycle-ack datapath model with A=25, B=38; steps spaced 10 cycles apart.
  - Required: `phase` visits 1,2,3,4,5,6,7,8,9,10,0; each request is high 2 cycles; `busy` matches; `error` stays 0.
- Sticky ack:
  - Stimulus: hold `display_a_ack` at 1 before entering REQ_DA.
  - Required: `display_a` is high exactly 1 cycle; HOLD_A is reached one edge after REQ_DA is entered.
- Ignored step:
  - Stimulus: pulse `step` every cycle while the ack model delays 5 cycles.
  - Required: no state skips; each REQ_* state is still entered once.
- Timeout:
  - Stimulus: ACK_TIMEOUT=8; `load_b_ack` held 0.
  - Required: `load_b` is high 9 cycles, then `phase`=15 and `error`=1. A subsequent `step` gives `phase`=0 and `error`=0.
- Reset mid-operation:
  - Stimulus: assert `RST` while `display_ls`=1.
  - Required: next edge all outputs are 0 and `phase`=0; a late `display_ls_ack` causes no transition.
- Ack/timeout race:
  - Stimulus: ACK_TIMEOUT=4; ack arrives on the timeout edge.
  - Required: the controller advances normally; `error` stays 0.
